// File: rtl/ram_burst_reader_if.sv
// Valid/ready stream carrying RAM words out of the burst reader.
// The master drives valid/data/last; the consumer drives ready.
interface ram_burst_reader_if #(
  parameter int DATA_W = 4
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read engine for a synchronous-read RAM: walks a wrapping address
// range and streams the words through a 2-entry buffer to a valid/ready sink.
module ram_burst_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_data_i,
  ram_burst_reader_if.master m
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_L = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ramAddr_q;
  logic [ADDR_W:0]   issueRem_q, issueRem_d;
  logic              inFlight_q;
  logic              inFlightLast_q;
  logic [DATA_W-1:0] bufData_q [2];
  logic              bufLast_q [2];
  logic              wrPtr_q;
  logic              rdPtr_q;
  logic [1:0]        count_q, count_d;

  logic [ADDR_W:0]   lenSat;
  logic              pop;
  logic              startBurst;
  logic              issueRun;
  logic              issue;
  logic [ADDR_W-1:0] issueAddr;
  logic              issueLast;
  logic [2:0]        occupancy;
  logic              headLast;

  // The first read goes out in the start cycle itself, so the RAM latency
  // overlaps the IDLE->RUN transition and the first beat appears 2 cycles later.
  always_comb begin
    lenSat     = (len_i > DEPTH) ? DEPTH : len_i;
    pop        = m.valid & m.ready;
    headLast   = bufLast_q[rdPtr_q];
    occupancy  = {1'b0, count_q} + {2'b00, inFlight_q};
    startBurst = (state_q == IDLE) && start_i && (lenSat != '0);
    issueRun   = (state_q == RUN) && (issueRem_q != '0) &&
                 (occupancy < (3'd2 + {2'b00, pop}));
    issue      = startBurst | issueRun;
    issueAddr  = startBurst ? start_addr_i : ptr_q;
    issueLast  = startBurst ? (lenSat == ONE_L) : (issueRem_q == ONE_L);
    ptr_d      = issue ? (issueAddr + ONE_A) : ptr_q;
    issueRem_d = issueRem_q;
    if (startBurst) begin
      issueRem_d = lenSat - ONE_L;
    end else if (issueRun) begin
      issueRem_d = issueRem_q - ONE_L;
    end
    count_d    = count_q + {1'b0, inFlight_q} - {1'b0, pop};
    ram_addr_o = issue ? issueAddr : ramAddr_q;
  end

  // Sequencing, address issue and the 2-entry buffer share one register block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      ramAddr_q      <= '0;
      issueRem_q     <= '0;
      inFlight_q     <= 1'b0;
      inFlightLast_q <= 1'b0;
      bufData_q[0]   <= '0;
      bufData_q[1]   <= '0;
      bufLast_q[0]   <= 1'b0;
      bufLast_q[1]   <= 1'b0;
      wrPtr_q        <= 1'b0;
      rdPtr_q        <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_q <= (lenSat != '0) ? RUN : FIN;
        RUN:  if (pop && headLast) state_q <= FIN;
        FIN:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      ptr_q          <= ptr_d;
      issueRem_q     <= issueRem_d;
      inFlight_q     <= issue;
      inFlightLast_q <= issueLast;
      if (issue) ramAddr_q <= issueAddr;
      // Word read last cycle is on ram_data_i now; the tag travels with it.
      if (inFlight_q) begin
        bufData_q[wrPtr_q] <= ram_data_i;
        bufLast_q[wrPtr_q] <= inFlightLast_q;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      count_q <= count_d;
    end
  end

  assign m.valid = (count_q != 2'd0);
  assign m.data  = bufData_q[rdPtr_q];
  assign m.last  = m.valid & headLast;
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == FIN);

endmodule
